gs_ddram_bridge: RTL and testbench

- Byte-wide memory port for the General Sound ROM/RAM image (up to 2 MB), backed by the DDR3 Avalon-style interface.
- Sits between the tsconf GS memory bus (addr/din/dout/rd/wr/wait) and the DDRAM_* pins; runs in the clk_mem domain that also drives DDRAM_CLK.
- Holds a one-line (64-bit) read cache to hide DDR3 latency on sequential Z80 fetches.
- Writes are write-through with byte enables.

---
 rtl/gs_ddram_bridge_pkg.sv | 19 +
 rtl/gs_ddram_bridge_if.sv | 30 +++
 rtl/gs_ddram_bridge.sv | 145 ++++++++++++++
 tb/tb_gs_ddram_bridge.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_ddram_bridge_pkg.sv
// Shared types and constants for the GS-to-DDR3 byte bridge.
// Holds no logic and adds no latency.
package gs_ddram_pkg;

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_e;

    localparam int LINE_W = 64;
    localparam int BSEL_W = 3;
    localparam int DDR_AW = 29;

    // GS image lives at byte 0x3000_0000 of DDR3, i.e. 64-bit word 0x0600_0000
    localparam logic [DDR_AW-1:0] BASE_DEFAULT = 29'h0600_0000;

    function automatic logic [7:0] sel_byte(input logic [LINE_W-1:0] line,
                                            input logic [BSEL_W-1:0] sel);
        return line[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/gs_ddram_bridge_if.sv
// GS byte bus (level rd/we, ready-based stall) and DDR3 Avalon-style command port.
// Wires only; the bridge owns all timing.
interface gs_mem_if #(parameter int ADDR_W = 21);
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    logic [7:0]        dout;
    logic              rd;
    logic              we;
    logic              ready;

    modport master (output addr, din, rd, we, input dout, ready);
    modport slave  (input addr, din, rd, we, output dout, ready);
endinterface

interface ddram_if;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    modport master (input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
                    output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE);
    modport slave  (output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
                    input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE);
endinterface

// File: rtl/gs_ddram_bridge.sv
// GS byte port onto DDR3 with a one-line read cache and write-through byte writes.
// Hit: dout next cycle, ready stays high; miss/write: ready low until DDR3 accepts/returns, stalls on DDRAM_BUSY.
module gs_ddram_bridge
    import gs_ddram_pkg::*;
#(
    parameter int                ADDR_W = 21,
    parameter logic [DDR_AW-1:0] BASE   = BASE_DEFAULT
) (
    input  logic    clk_mem,
    input  logic    reset_n,
    gs_mem_if.slave gs,
    ddram_if.master ddr
);

    localparam int WORD_W = ADDR_W - BSEL_W;

    state_e              state_q, state_d;
    logic                rd_prev_q, we_prev_q;
    logic [ADDR_W-1:0]   addr_prev_q;
    logic [7:0]          dout_q, dout_d;
    logic                ready_q, ready_d;
    logic                ddr_rd_q, ddr_rd_d;
    logic                ddr_we_q, ddr_we_d;
    logic [7:0]          ddr_be_q, ddr_be_d;
    logic [LINE_W-1:0]   ddr_din_q, ddr_din_d;
    logic [DDR_AW-1:0]   ddr_addr_q, ddr_addr_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [WORD_W-1:0]   tag_q, tag_d;
    logic                valid_q, valid_d;

    logic [WORD_W-1:0]   word;
    logic [BSEL_W-1:0]   sel;
    logic                new_req;
    logic                hit;

    assign word    = gs.addr[ADDR_W-1:BSEL_W];
    assign sel     = gs.addr[BSEL_W-1:0];
    // A held level request only counts once; a new address re-arms it
    assign new_req = (gs.rd | gs.we) & (~(rd_prev_q | we_prev_q) | (gs.addr != addr_prev_q));
    assign hit     = valid_q & (tag_q == word);

    always_comb begin
        state_d    = state_q;
        dout_d     = dout_q;
        ready_d    = ready_q;
        ddr_rd_d   = ddr_rd_q;
        ddr_we_d   = ddr_we_q;
        ddr_be_d   = ddr_be_q;
        ddr_din_d  = ddr_din_q;
        ddr_addr_d = ddr_addr_q;
        line_d     = line_q;
        tag_d      = tag_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                if (new_req) begin
                    if (gs.we) begin
                        state_d    = WR_REQ;
                        ready_d    = 1'b0;
                        ddr_we_d   = 1'b1;
                        ddr_din_d  = {8{gs.din}};
                        ddr_be_d   = 8'b1 << sel;
                        ddr_addr_d = BASE + DDR_AW'(word);
                        if (hit) line_d[{sel, 3'b000} +: 8] = gs.din;
                    end else if (hit) begin
                        dout_d = sel_byte(line_q, sel);
                    end else begin
                        state_d    = RD_REQ;
                        ready_d    = 1'b0;
                        ddr_rd_d   = 1'b1;
                        ddr_addr_d = BASE + DDR_AW'(word);
                    end
                end
            end
            RD_REQ: begin
                if (!ddr.DDRAM_BUSY) begin
                    ddr_rd_d = 1'b0;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (ddr.DDRAM_DOUT_READY) begin
                    line_d  = ddr.DDRAM_DOUT;
                    tag_d   = word;
                    valid_d = 1'b1;
                    dout_d  = sel_byte(ddr.DDRAM_DOUT, sel);
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                if (!ddr.DDRAM_BUSY) begin
                    ddr_we_d = 1'b0;
                    ready_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rd_prev_q   <= 1'b0;
            we_prev_q   <= 1'b0;
            addr_prev_q <= '0;
            dout_q      <= 8'hFF;
            ready_q     <= 1'b1;
            ddr_rd_q    <= 1'b0;
            ddr_we_q    <= 1'b0;
            ddr_be_q    <= '0;
            ddr_din_q   <= '0;
            ddr_addr_q  <= BASE;
            line_q      <= '0;
            tag_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_prev_q   <= gs.rd;
            we_prev_q   <= gs.we;
            addr_prev_q <= gs.addr;
            dout_q      <= dout_d;
            ready_q     <= ready_d;
            ddr_rd_q    <= ddr_rd_d;
            ddr_we_q    <= ddr_we_d;
            ddr_be_q    <= ddr_be_d;
            ddr_din_q   <= ddr_din_d;
            ddr_addr_q  <= ddr_addr_d;
            line_q      <= line_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
        end
    end

    assign gs.dout            = dout_q;
    assign gs.ready           = ready_q;
    assign ddr.DDRAM_BURSTCNT = 8'd1;
    assign ddr.DDRAM_ADDR     = ddr_addr_q;
    assign ddr.DDRAM_RD       = ddr_rd_q;
    assign ddr.DDRAM_DIN      = ddr_din_q;
    assign ddr.DDRAM_BE       = ddr_be_q;
    assign ddr.DDRAM_WE       = ddr_we_q;

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// Bench for gs_ddram_bridge: DDR3 memory model plus byte-level reference memory and cache-occupancy model.
module tb_gs_ddram_bridge;
    import gs_ddram_pkg::*;

    localparam int          AW     = 21;
    localparam logic [28:0] BASE_W = BASE_DEFAULT;

    logic clk_mem = 1'b0;
    logic reset_n;
    always #5 clk_mem = ~clk_mem;

    gs_mem_if #(.ADDR_W(AW)) gs();
    ddram_if ddr();

    gs_ddram_bridge #(.ADDR_W(AW), .BASE(BASE_W)) dut (
        .clk_mem (clk_mem),
        .reset_n (reset_n),
        .gs      (gs),
        .ddr     (ddr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: DUT event did not occur within bound", nm);
    endtask

    // Reference contents: unwritten bytes follow a fixed pattern
    function automatic logic [7:0] init_byte(input logic [20:0] a);
        return 8'(a - 21'h10);
    endfunction

    logic [7:0]  ref_mem   [int];
    logic [63:0] ddr_store [int];

    function automatic logic [7:0] ref_rd(input logic [20:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_byte(a);
    endfunction

    function automatic logic [63:0] ddr_word(input int w);
        logic [63:0] v;
        if (ddr_store.exists(w)) return ddr_store[w];
        for (int k = 0; k < 8; k++)
            v[8*k +: 8] = init_byte(21'((w - int'(BASE_W)) * 8 + k));
        return v;
    endfunction

    // DDR3 model
    typedef struct { int due; logic [63:0] data; } resp_t;
    resp_t rq[$];
    int cyc = 0, rd_cmds = 0, wr_cmds = 0, stale_seen = 0;
    int lat_cfg = 10, busy_cfg = 0, busy_run = 0;

    always @(posedge clk_mem) begin
        logic [63:0] w;
        int          wa;
        cyc++;
        if (ddr.DDRAM_RD === 1'b1 && ddr.DDRAM_BUSY === 1'b0) begin
            rd_cmds++;
            rq.push_back('{cyc + lat_cfg, ddr_word(int'(ddr.DDRAM_ADDR))});
        end
        if (ddr.DDRAM_WE === 1'b1 && ddr.DDRAM_BUSY === 1'b0) begin
            wr_cmds++;
            wa = int'(ddr.DDRAM_ADDR);
            w  = ddr_word(wa);
            for (int k = 0; k < 8; k++)
                if (ddr.DDRAM_BE[k]) w[8*k +: 8] = ddr.DDRAM_DIN[8*k +: 8];
            ddr_store[wa] = w;
        end
    end

    always @(negedge clk_mem) begin
        if (ddr.DDRAM_RD === 1'b1 || ddr.DDRAM_WE === 1'b1) begin
            ddr.DDRAM_BUSY = (busy_run < busy_cfg);
            busy_run++;
        end else begin
            ddr.DDRAM_BUSY = 1'b0;
            busy_run = 0;
        end
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            ddr.DDRAM_DOUT_READY = 1'b1;
            ddr.DDRAM_DOUT       = rq[0].data;
            void'(rq.pop_front());
            stale_seen++;
        end else begin
            ddr.DDRAM_DOUT_READY = 1'b0;
            ddr.DDRAM_DOUT       = {$urandom, $urandom};
        end
    end

    // Command monitor
    logic [28:0] exp_cmd_addr;
    logic [7:0]  exp_be;
    logic [63:0] exp_din;
    logic [28:0] last_cmd_addr = '0;
    logic [7:0]  last_be = '0;
    logic [63:0] last_din = '0;
    int          rd_hi_tot = 0, we_hi_tot = 0;

    always @(negedge clk_mem) begin
        chk("burstcnt", ddr.DDRAM_BURSTCNT, 64'd1);
        if (ddr.DDRAM_RD === 1'b1 && ddr.DDRAM_WE === 1'b1) fail_now("rd_we_both_high");
        if (ddr.DDRAM_RD === 1'b1) begin
            rd_hi_tot++;
            chk("rd_cmd_addr", ddr.DDRAM_ADDR, exp_cmd_addr);
            last_cmd_addr = ddr.DDRAM_ADDR;
        end
        if (ddr.DDRAM_WE === 1'b1) begin
            we_hi_tot++;
            chk("wr_cmd_addr", ddr.DDRAM_ADDR, exp_cmd_addr);
            chk("wr_be", ddr.DDRAM_BE, exp_be);
            chk("wr_din", ddr.DDRAM_DIN, exp_din);
            last_cmd_addr = ddr.DDRAM_ADDR;
            last_be       = ddr.DDRAM_BE;
            last_din      = ddr.DDRAM_DIN;
        end
    end

    // Which 64-bit word the bridge currently holds, if any
    bit          mdl_valid = 1'b0;
    logic [17:0] mdl_word  = '0;

    task automatic op(input bit r, input bit w, input logic [20:0] a, input logic [7:0] d,
                      input int busy, input bit hold);
        bit         exp_hit;
        logic [7:0] exp_b;
        int         rc0, wc0, rh0, wh0, waited;
        exp_hit = !w && mdl_valid && (mdl_word == a[20:3]);
        exp_b   = ref_rd(a);
        rc0 = rd_cmds; wc0 = wr_cmds; waited = 0;
        @(negedge clk_mem);
        rh0 = rd_hi_tot; wh0 = we_hi_tot;
        gs.rd = r; gs.we = w; gs.addr = a; gs.din = d;
        busy_cfg     = busy;
        exp_cmd_addr = BASE_W + 29'(a[20:3]);
        exp_be       = 8'b1 << a[2:0];
        exp_din      = {8{d}};
        @(negedge clk_mem);
        if (exp_hit) begin
            chk("hit_ready", gs.ready, 64'd1);
            chk("hit_dout", gs.dout, exp_b);
        end else begin
            chk("op_ready_low", gs.ready, 64'd0);
            while (gs.ready !== 1'b1 && waited < 300) begin
                @(negedge clk_mem);
                waited++;
            end
            if (waited >= 300) fail_now("op_complete_timeout");
            if (!w) begin
                chk("miss_dout", gs.dout, exp_b);
                chk("rd_hold_cycles", rd_hi_tot - rh0, busy + 1);
            end else begin
                chk("we_hold_cycles", we_hi_tot - wh0, busy + 1);
            end
        end
        if (!hold) begin
            gs.rd = 1'b0; gs.we = 1'b0;
            @(negedge clk_mem);
        end
        chk("rd_cmd_count", rd_cmds - rc0, (w || exp_hit) ? 0 : 1);
        chk("wr_cmd_count", wr_cmds - wc0, w ? 1 : 0);
        if (w) ref_mem[int'(a)] = d;
        else if (!exp_hit) begin
            mdl_valid = 1'b1;
            mdl_word  = a[20:3];
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", gs.ready, 64'd1);
        chk("rst_dout", gs.dout, 64'hFF);
        chk("rst_ddr_rd", ddr.DDRAM_RD, 64'd0);
        chk("rst_ddr_we", ddr.DDRAM_WE, 64'd0);
        chk("rst_ddr_be", ddr.DDRAM_BE, 64'd0);
        chk("rst_ddr_din", ddr.DDRAM_DIN, 64'd0);
        chk("rst_ddr_addr", ddr.DDRAM_ADDR, 64'h0600_0000);
    endtask

    initial begin
        int          rc0, wc0, s0, waited, kind;
        logic [20:0] a;
        reset_n = 1'b0;
        gs.rd = 1'b0; gs.we = 1'b0; gs.addr = '0; gs.din = '0;
        exp_cmd_addr = '0; exp_be = '0; exp_din = '0;
        repeat (3) @(negedge clk_mem);
        reset_n = 1'b1;
        @(negedge clk_mem);
        chk_reset_vals();

        op(1'b1, 1'b0, 21'h00010, 8'h00, 0, 1'b0);
        chk("t1_ddr_addr", last_cmd_addr, 64'h0600_0002);
        chk("t1_dout", gs.dout, 64'h00);

        op(1'b1, 1'b0, 21'h00013, 8'h00, 0, 1'b0);
        chk("t2_hit_dout", gs.dout, 64'h03);

        op(1'b0, 1'b1, 21'h00015, 8'hA5, 3, 1'b0);
        chk("t3_be", last_be, 64'h20);
        chk("t3_din", last_din, 64'hA5A5_A5A5_A5A5_A5A5);

        op(1'b1, 1'b0, 21'h00015, 8'h00, 0, 1'b0);
        chk("t3_hit_after_write", gs.dout, 64'hA5);

        rc0 = rd_cmds; wc0 = wr_cmds;
        op(1'b1, 1'b1, 21'h00015, 8'h5A, 1, 1'b1);
        repeat (50) @(negedge clk_mem);
        chk("hold_single_wr", wr_cmds - wc0, 64'd1);
        chk("hold_no_rd", rd_cmds - rc0, 64'd0);
        chk("hold_ready", gs.ready, 64'd1);
        op(1'b1, 1'b0, 21'h1FFFF8, 8'h00, 2, 1'b0);
        chk("t4_ddr_addr", last_cmd_addr, 64'h0603_FFFF);

        // Reset while a read is outstanding; its data arrives afterwards
        lat_cfg = 25; busy_cfg = 0; waited = 0;
        rc0 = rd_cmds;
        @(negedge clk_mem);
        gs.rd = 1'b1; gs.addr = 21'h00020;
        exp_cmd_addr = BASE_W + 29'h4;
        while (rd_cmds == rc0 && waited < 50) begin
            @(negedge clk_mem);
            waited++;
        end
        if (waited >= 50) fail_now("rst_rd_accept_timeout");
        repeat (3) @(negedge clk_mem);
        s0 = stale_seen;
        reset_n = 1'b0; gs.rd = 1'b0;
        mdl_valid = 1'b0;
        repeat (2) @(negedge clk_mem);
        reset_n = 1'b1;
        @(negedge clk_mem);
        chk_reset_vals();
        repeat (30) @(negedge clk_mem);
        chk("stale_delivered", stale_seen - s0, 64'd1);
        chk("stale_ready", gs.ready, 64'd1);
        chk("stale_dout", gs.dout, 64'hFF);
        lat_cfg = 10;
        op(1'b1, 1'b0, 21'h00020, 8'h00, 0, 1'b0);

        op(1'b1, 1'b1, 21'h00008, 8'h3C, 1, 1'b0);
        chk("t6_be", last_be, 64'h01);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            a = 21'($urandom_range(0, 47));
            if ($urandom_range(0, 3) == 0) a = a | 21'h1FFF00;
            lat_cfg = $urandom_range(1, 12);
            op(kind <= 5 || kind == 9, kind >= 6, a, 8'($urandom), $urandom_range(0, 3), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
